data_mem_bytelane: RTL and testbench
====================================

DATA_MEM_BYTELANE -- requirements
Module: data_mem_bytelane

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter INIT_WORD0, default 32'd10, value loaded into word 0 by the clear sequence.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port MemWrite  in  1  store request, sampled at posedge while ready=1.
REQ-007 SHALL have port MemRead  in  1  load request, sampled at posedge while ready=1.
REQ-008 SHALL have port size  in  2  access size: 0 byte, 1 halfword, 2 word, 3 reserved (treated as word).
REQ-009 SHALL have port load_unsigned  in  1  1 zero-extends sub-word loads, 0 sign-extends them.
REQ-010 SHALL have port address  in  32  byte address; word index is address[log2(DEPTH_WORDS)+1:2] and upper bits are ignored, so addresses wrap.
REQ-011 SHALL have port data_in  in  32  store data, right-justified: byte in [7:0], halfword in [15:0].
REQ-012 SHALL have port read_data  out  32  registered, extended load result.
REQ-013 SHALL have port read_valid  out  1  one-cycle pulse marking read_data as new.
REQ-014 SHALL have port misaligned  out  1  one-cycle pulse reporting a rejected access.
REQ-015 SHALL have port ready  out  1  high when the block accepts requests.

Function
REQ-016 SHALL implement states CLEAR and IDLE.
REQ-017 In CLEAR, the block SHALL write one word per cycle at index 0..DEPTH_WORDS-1: INIT_WORD0 at index 0, zero elsewhere.
REQ-018 After the last index is written, the block SHALL go to IDLE, so ready rises exactly DEPTH_WORDS cycles after reset deasserts.
REQ-019 While ready=0, MemRead and MemWrite SHALL be ignored and no outputs pulse.
REQ-020 Byte lanes SHALL be little-endian: byte at offset k maps to word bits [8k+7:8k]; halfword offset 2 maps to [31:16].
REQ-021 A store SHALL update only the addressed lanes at the accepting posedge; other lanes are unchanged.
REQ-022 A load SHALL have 1-cycle latency: read_data and read_valid=1 are updated at the posedge after acceptance.
REQ-023 read_data SHALL hold its value until the next valid load.
REQ-024 The load result SHALL be the addressed byte or halfword shifted to bit 0, then extended per load_unsigned; a word load is returned unmodified.
REQ-025 A halfword access with address[0]=1, or a word access with address[1:0]!=0, SHALL be rejected.
REQ-026 A rejected access SHALL not modify memory, SHALL leave read_data unchanged, SHALL pulse misaligned for 1 cycle with read_valid=0, and SHALL not pulse misaligned for reserved size=3 when the word is aligned.
REQ-027 If MemWrite and MemRead are high together, the store SHALL be performed and the load SHALL be dropped (no read_valid).
REQ-028 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-029 Back-to-back loads on consecutive cycles SHALL each produce one read_valid pulse, giving full throughput.

Reset
REQ-030 Asserting reset SHALL immediately force read_data=0, read_valid=0, misaligned=0, ready=0, state=CLEAR, and clear index=0.
REQ-031 Reset asserted mid-CLEAR or mid-access SHALL abort it; the clear restarts from index 0 after deassert, and any in-flight load produces no read_valid.
REQ-032 Memory array contents SHALL not be reset directly; the CLEAR sequence alone initialises them.

Structure
REQ-033 Size encodings (BYTE, HALF, WORD) and the state encoding SHALL live in shared package mips_mem_pkg.
REQ-034 Lane write-enable generation, load extraction and extension SHALL be one combinational sub-module mem_lane_align; the array and FSM stay in data_mem_bytelane.

Verification
REQ-035 Clear sequence: release reset with DEPTH_WORDS=16 -> ready=0 for 16 cycles, then 1; a word load at 0x0 returns 10, and at 0x3C returns 0.
REQ-036 Byte store and extension: SW 0x11223344 @0x8; SB data_in=0xAB @0x9 -> LW @0x8 = 0x1122AB44; LB @0x9 = 0xFFFFFFAB; LBU @0x9 = 0x000000AB.
REQ-037 Halfword: SH 0x8001 @0x12 -> LH @0x12 = 0xFFFF8001, LHU @0x12 = 0x00008001, and LW @0x10 has [31:16]=0x8001.
REQ-038 Misaligned: SW @0x6 -> misaligned pulse and word 1 unchanged; LH @0x1 -> misaligned pulse, no read_valid, and read_data keeps its previous value.
REQ-039 Simultaneous request and wrap: MemRead=MemWrite=1, SW 0xDEADBEEF @0x40 with DEPTH_WORDS=16 -> no read_valid; the next-cycle LW @0x0 returns 0xDEADBEEF.
REQ-040 Reset mid-clear: assert reset at clear index 7, hold 2 cycles -> outputs reach 0 asynchronously, and ready rises exactly 16 cycles after the second deassert.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, FSM states, load request.
// Pure declarations; no latency or flow control of its own.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    size_e      size;
    logic [1:0] off;
    logic       uns;
  } lane_req_t;

  // Reserved size is handled as a word access, alignment included.
  function automatic logic is_misaligned(input size_e s, input logic [1:0] off);
    case (s)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables/replicated data, alignment check, load extract+extend.
// Purely combinational; no state, no backpressure.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_misaligned,
  input  lane_req_t   ld_req,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign st_misaligned = is_misaligned(st_size, st_off);

  always_comb begin
    case (ld_req.off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_req.off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_req.size)
      SIZE_BYTE: ld_data = ld_req.uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = ld_req.uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressable data memory with self-clearing sequence after reset; loads return one cycle after acceptance.
// Requests are accepted only while ready=1; during the clear sequence they are silently ignored.
module data_mem_bytelane
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] INIT_WORD0  = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misaligned,
  output logic        ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  state_e        state;
  logic [AW-1:0] clr_idx;
  logic          ld_pend;
  logic [AW-1:0] ld_idx;
  lane_req_t     ld_req;

  logic [AW-1:0] req_idx;
  size_e         req_size;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic          st_mis;
  logic [31:0]   ld_data;
  logic          st_acc, ld_acc, req_any;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          unused_addr;

  assign req_idx     = address[AW+1:2];
  assign req_size    = size_e'(size);
  assign unused_addr = ^address[31:AW+2];

  mem_lane_align u_align (
    .st_size       (req_size),
    .st_off        (address[1:0]),
    .st_data       (data_in),
    .st_be         (st_be),
    .st_wdata      (st_wdata),
    .st_misaligned (st_mis),
    .ld_req        (ld_req),
    .ld_word       (mem[ld_idx]),
    .ld_data       (ld_data)
  );

  // A simultaneous read is dropped in favour of the store.
  assign req_any = ready && (MemWrite || MemRead);
  assign st_acc  = ready && MemWrite && !st_mis;
  assign ld_acc  = ready && MemRead && !MemWrite && !st_mis;

  always_comb begin
    mem_we    = st_acc;
    mem_idx   = req_idx;
    mem_be    = st_be;
    mem_wdata = st_wdata;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx;
      mem_be    = 4'b1111;
      mem_wdata = (clr_idx == '0) ? INIT_WORD0 : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_idx    <= '0;
      ready      <= 1'b0;
      read_data  <= 32'd0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
      ld_pend    <= 1'b0;
      ld_idx     <= '0;
      ld_req     <= '0;
    end else begin
      read_valid <= ld_pend;
      if (ld_pend) read_data <= ld_data;
      ld_pend    <= ld_acc;
      misaligned <= req_any && st_mis;
      if (ld_acc) begin
        ld_idx <= req_idx;
        ld_req <= '{size: req_size, off: address[1:0], uns: load_unsigned};
      end
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH_WORDS - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench for data_mem_bytelane (16 words): scoreboard queue of expected load results.
module tb_data_mem_bytelane;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        load_unsigned = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  data_mem_bytelane #(.DEPTH_WORDS(16), .INIT_WORD0(32'd10)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .size          (size),
    .load_unsigned (load_unsigned),
    .address       (address),
    .data_in       (data_in),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .misaligned    (misaligned),
    .ready         (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = we; MemRead = re; size = sz; load_unsigned = uns; address = a; data_in = d;
  endtask

  task automatic idle();
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, 1'b0, sz, 1'b0, a, d);
    idle();
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    issue(1'b0, 1'b1, sz, uns, a, 32'd0);
    idle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, 32'd16);
  endtask

  always @(posedge clk) begin : monitor
    logic [31:0] e;
    #1;
    if (read_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_read_valid: observed read_data %h, required no pulse", read_data);
      end else begin
        e = sb.pop_front();
        check("load_data", read_data, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_read_valid", read_valid, 32'd0);
    check("rst_misaligned", misaligned, 32'd0);
    check("rst_ready", ready, 32'd0);

    reset = 1'b0;
    wait_ready("clear_cycles");
    load(SIZE_WORD, 1'b0, 32'h0, 32'd10);
    load(SIZE_WORD, 1'b0, 32'h3C, 32'd0);

    // Byte lanes and extension
    store(SIZE_WORD, 32'h8, 32'h11223344);
    store(SIZE_BYTE, 32'h9, 32'h000000AB);
    load(SIZE_WORD, 1'b0, 32'h8, 32'h1122AB44);
    load(SIZE_BYTE, 1'b0, 32'h9, 32'hFFFFFFAB);
    load(SIZE_BYTE, 1'b1, 32'h9, 32'h000000AB);

    store(SIZE_HALF, 32'h12, 32'h00008001);
    load(SIZE_HALF, 1'b0, 32'h12, 32'hFFFF8001);
    load(SIZE_HALF, 1'b1, 32'h12, 32'h00008001);
    load(SIZE_WORD, 1'b0, 32'h10, 32'h80010000);

    // Misaligned store leaves word 1 untouched
    store(SIZE_WORD, 32'h6, 32'hCAFEF00D);
    check("sw_mis_pulse", misaligned, 32'd1);
    @(negedge clk);
    check("sw_mis_clear", misaligned, 32'd0);
    check("sw_mis_no_valid", read_valid, 32'd0);
    load(SIZE_WORD, 1'b0, 32'h4, 32'd0);

    load(SIZE_WORD, 1'b0, 32'h8, 32'h1122AB44);
    issue(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h1, 32'd0);
    idle();
    check("lh_mis_pulse", misaligned, 32'd1);
    @(posedge clk);
    #2;
    check("lh_mis_no_valid", read_valid, 32'd0);
    check("lh_mis_hold_data", read_data, 32'h1122AB44);
    check("lh_mis_clear", misaligned, 32'd0);

    // Store+load together, wrapped address, then forwarding on the next cycle
    issue(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'hDEADBEEF);
    sb.push_back(32'hDEADBEEF);
    issue(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'd0);
    @(posedge clk);
    #2;
    check("both_no_valid", read_valid, 32'd0);
    idle();
    @(posedge clk);
    #2;

    // Back-to-back loads
    sb.push_back(32'h00000044);
    sb.push_back(32'h00000022);
    sb.push_back(32'h00001122);
    issue(1'b0, 1'b1, SIZE_BYTE, 1'b1, 32'h8, 32'd0);
    issue(1'b0, 1'b1, SIZE_BYTE, 1'b1, 32'hA, 32'd0);
    issue(1'b0, 1'b1, SIZE_HALF, 1'b1, 32'hA, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("b2b_drained", sb.size(), 32'd0);

    // Async reset with a load in flight
    issue(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h8, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    MemRead = 1'b0;
    #1;
    check("arst_read_data", read_data, 32'd0);
    check("arst_read_valid", read_valid, 32'd0);
    check("arst_ready", ready, 32'd0);
    check("arst_misaligned", misaligned, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Abort the clear at index 7
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midclear_ready", ready, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ready("clear_cycles_restart");
    load(SIZE_WORD, 1'b0, 32'h0, 32'd10);
    load(SIZE_WORD, 1'b0, 32'h8, 32'd0);

    check("final_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
